bit_pair_monitor: RTL and testbench

Parametrised, clocked checker that verifies, every enabled cycle, that `foo[i] && bar[i]` holds for every bit index `i` in a configurable range `[LO:HI]` of two `WIDTH`-bit buses. It is the successor of the fixed 12-bit / 10-lane assertion block. It adds registered per-lane failure reporting, sticky history, saturating failure counting, first-failure capture and a consecutive-failure alarm state machine. It sits beside the datapath as a synthesizable monitor whose outputs feed status registers and the bench scoreboard.

---
 rtl/bit_pair_monitor.sv | 161 ++++++++++++++++
 tb/tb_bit_pair_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bit_pair_monitor.sv
`default_nettype none
// ============================================================================
// Module   : bit_pair_monitor
// Purpose  : Checks that foo[i] && bar[i] holds for every lane in [LO:HI] on
//            each enabled cycle. Reports registered per-lane failures, sticky
//            history, saturating counts, first-failure capture and an alarm
//            raised after THRESH consecutive failing samples.
// Revision : 1.0 - initial release
// ============================================================================
module bit_pair_monitor #(
  parameter int WIDTH  = 12,
  parameter int LO     = 0,
  parameter int HI     = 9,
  parameter int CNT_W  = 8,
  parameter int THRESH = 3,
  parameter int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] foo,
  input  logic [WIDTH-1:0] bar,
  output logic [WIDTH-1:0] fail_mask,
  output logic [WIDTH-1:0] sticky_mask,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_valid,
  output logic [IDX_W-1:0] first_idx,
  output logic [CNT_W-1:0] streak,
  output logic             alarm,
  output logic [1:0]       state
);

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_monitor = 2'd1;
  localparam logic [1:0] c_alarm   = 2'd2;

  // Lanes LO..HI inclusive are checked; everything else is forced to pass.
  localparam logic [WIDTH-1:0] c_range =
    ({WIDTH{1'b1}} << LO) & ({WIDTH{1'b1}} >> (WIDTH - 1 - HI));

  localparam logic [CNT_W-1:0] c_thresh = CNT_W'(THRESH);

  logic [WIDTH-1:0] w_lane_fail;
  logic             w_fail;
  logic [IDX_W-1:0] w_low_idx;
  logic             w_sample;
  logic [CNT_W-1:0] w_streak_nxt;
  logic [1:0]       w_state_nxt;
  logic             w_alarm_nxt;

  logic [WIDTH-1:0] r_fail_mask;
  logic [WIDTH-1:0] r_sticky;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first_valid;
  logic [IDX_W-1:0] r_first_idx;
  logic [CNT_W-1:0] r_streak;
  logic             r_alarm;
  logic [1:0]       r_state;

  // Per-lane check; anything other than a clean 1 on both operands fails.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign w_lane_fail[i] = c_range[i] & ((foo[i] & bar[i]) !== 1'b1);
  end

  assign w_fail   = |w_lane_fail;
  assign w_sample = enable & ~clear;

  // Lowest failing lane index (scan from the top so the lowest wins).
  always_comb begin
    w_low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (w_lane_fail[i]) w_low_idx = IDX_W'(i);
    end
  end

  // Streak value after this edge; the FSM compares against it directly so the
  // alarm rises on the same edge that the streak reaches THRESH.
  always_comb begin
    w_streak_nxt = r_streak;
    if (clear) begin
      w_streak_nxt = '0;
    end else if (enable) begin
      if (!w_fail)                w_streak_nxt = '0;
      else if (r_streak != '1)    w_streak_nxt = r_streak + 1'b1;
    end
  end

  // Datapath history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_mask   <= '0;
      r_sticky      <= '0;
      r_cnt         <= '0;
      r_first_valid <= 1'b0;
      r_first_idx   <= '0;
      r_streak      <= '0;
    end else begin
      r_fail_mask <= enable ? w_lane_fail : '0;
      r_streak    <= w_streak_nxt;
      if (clear) begin
        r_sticky      <= '0;
        r_cnt         <= '0;
        r_first_valid <= 1'b0;
        r_first_idx   <= '0;
      end else if (w_sample) begin
        r_sticky <= r_sticky | w_lane_fail;
        if (w_fail && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        if (w_fail && !r_first_valid) begin
          r_first_valid <= 1'b1;
          r_first_idx   <= w_low_idx;
        end
      end
    end
  end

  // FSM state register; alarm is registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alarm <= w_alarm_nxt;
    end
  end

  // FSM next-state; clear overrides every transition including ALARM.
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = enable ? c_monitor : c_idle;
    end else begin
      case (r_state)
        c_idle:    if (enable) w_state_nxt = c_monitor;
        c_monitor: begin
          if (!enable)                        w_state_nxt = c_idle;
          else if (w_streak_nxt >= c_thresh)  w_state_nxt = c_alarm;
        end
        c_alarm:   w_state_nxt = c_alarm;
        default:   w_state_nxt = c_idle;
      endcase
    end
  end

  // FSM output decode, registered in the state register block.
  always_comb begin
    w_alarm_nxt = (w_state_nxt == c_alarm);
  end

  assign fail_mask   = r_fail_mask;
  assign sticky_mask = r_sticky;
  assign fail_cnt    = r_cnt;
  assign first_valid = r_first_valid;
  assign first_idx   = r_first_idx;
  assign streak      = r_streak;
  assign alarm       = r_alarm;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bit_pair_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_pair_monitor
// Purpose  : Directed self-checking bench for bit_pair_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_pair_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [11:0] foo;
  logic [11:0] bar;

  logic [11:0] fail_mask,  sticky_mask;
  logic [3:0]  fail_cnt,   streak;
  logic        first_valid, alarm;
  logic [3:0]  first_idx;
  logic [1:0]  state;

  logic [11:0] fail_mask2, sticky_mask2;
  logic [3:0]  fail_cnt2,  streak2;
  logic        first_valid2, alarm2;
  logic [3:0]  first_idx2;
  logic [1:0]  state2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bit_pair_monitor #(.WIDTH(12), .LO(0), .HI(9), .CNT_W(4), .THRESH(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .foo(foo), .bar(bar),
    .fail_mask(fail_mask), .sticky_mask(sticky_mask), .fail_cnt(fail_cnt),
    .first_valid(first_valid), .first_idx(first_idx), .streak(streak),
    .alarm(alarm), .state(state)
  );

  bit_pair_monitor #(.WIDTH(12), .LO(0), .HI(9), .CNT_W(4), .THRESH(15)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .foo(foo), .bar(bar),
    .fail_mask(fail_mask2), .sticky_mask(sticky_mask2), .fail_cnt(fail_cnt2),
    .first_valid(first_valid2), .first_idx(first_idx2), .streak(streak2),
    .alarm(alarm2), .state(state2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; clear = 1'b0;
    foo = 12'hFFF; bar = 12'hFFF;

    // Reset holds everything at zero across edges.
    step(); step();
    check("rst_fail_mask", 32'(fail_mask), 32'h0);
    check("rst_state",     32'(state),     32'h0);
    check("rst_cnt",       32'(fail_cnt),  32'h0);
    check("rst_alarm",     32'(alarm),     32'h0);
    rst_n = 1'b1;
    step();
    check("post_rst_mask",  32'(fail_mask), 32'h0);
    check("post_rst_state", 32'(state),     32'h1);

    // Single lane fault on lane 5.
    bar = 12'hFDF;
    step();
    check("sl_mask",   32'(fail_mask),   32'h020);
    check("sl_sticky", 32'(sticky_mask), 32'h020);
    check("sl_cnt",    32'(fail_cnt),    32'h1);
    check("sl_fidx",   32'(first_idx),   32'h5);
    check("sl_fvalid", 32'(first_valid), 32'h1);
    check("sl_streak", 32'(streak),      32'h1);
    bar = 12'hFFF;
    step();
    check("pass_streak", 32'(streak),      32'h0);
    check("pass_mask",   32'(fail_mask),   32'h0);
    check("pass_sticky", 32'(sticky_mask), 32'h020);

    // Lane 11 is outside [0:9].
    bar = 12'h7FF;
    step();
    check("oor_mask", 32'(fail_mask), 32'h0);
    check("oor_cnt",  32'(fail_cnt),  32'h1);
    bar = 12'hFFF;

    // Three consecutive failures on lane 0 raise the alarm.
    foo = 12'hFFE;
    step();
    check("al_streak1", 32'(streak), 32'h1);
    check("al_alarm1",  32'(alarm),  32'h0);
    step();
    check("al_streak2", 32'(streak), 32'h2);
    check("al_alarm2",  32'(alarm),  32'h0);
    step();
    check("al_streak3", 32'(streak),      32'h3);
    check("al_alarm3",  32'(alarm),       32'h1);
    check("al_state3",  32'(state),       32'h2);
    check("al_cnt",     32'(fail_cnt),    32'h4);
    check("al_fidx",    32'(first_idx),   32'h5);
    check("al_sticky",  32'(sticky_mask), 32'h021);

    // Alarm survives a pass and a disabled cycle.
    foo = 12'hFFF;
    step();
    check("hold_streak", 32'(streak), 32'h0);
    check("hold_alarm",  32'(alarm),  32'h1);
    enable = 1'b0;
    step();
    check("dis_alarm", 32'(alarm), 32'h1);
    check("dis_state", 32'(state), 32'h2);

    // Failure while disabled is not sampled.
    foo = 12'hFFE;
    step();
    check("dis_mask", 32'(fail_mask), 32'h0);
    check("dis_cnt",  32'(fail_cnt),  32'h4);

    // Clear has priority over a failing sample.
    enable = 1'b1; clear = 1'b1;
    step();
    check("clr_mask",   32'(fail_mask),   32'h001);
    check("clr_cnt",    32'(fail_cnt),    32'h0);
    check("clr_fvalid", 32'(first_valid), 32'h0);
    check("clr_sticky", 32'(sticky_mask), 32'h0);
    check("clr_alarm",  32'(alarm),       32'h0);
    check("clr_state",  32'(state),       32'h1);
    check("clr_streak", 32'(streak),      32'h0);
    clear = 1'b0;

    // Multi-lane failure: lowest index captured and then frozen.
    foo = 12'hFFF; bar = 12'hEF7;
    step();
    check("ml_mask", 32'(fail_mask), 32'h108);
    check("ml_fidx", 32'(first_idx), 32'h3);
    check("ml_cnt",  32'(fail_cnt),  32'h1);
    bar = 12'hFFB;
    step();
    check("ml2_fidx",   32'(first_idx),   32'h3);
    check("ml2_sticky", 32'(sticky_mask), 32'h10C);
    check("ml2_streak", 32'(streak),      32'h2);
    check("ml2_state",  32'(state),       32'h1);

    // Asynchronous reset between edges while streak = 2.
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_streak", 32'(streak),      32'h0);
    check("ar_cnt",    32'(fail_cnt),    32'h0);
    check("ar_sticky", 32'(sticky_mask), 32'h0);
    check("ar_mask",   32'(fail_mask),   32'h0);
    check("ar_state",  32'(state),       32'h0);
    check("ar_fvalid", 32'(first_valid), 32'h0);
    bar = 12'hFFF;
    #2;
    rst_n = 1'b1;
    step();
    check("ar_rel_state", 32'(state), 32'h1);

    // Saturation with THRESH = 15 on the second instance.
    foo = 12'hFFE;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) check("sat_alarm14", 32'(alarm2), 32'h0);
      if (k == 15) begin
        check("sat_alarm15",  32'(alarm2),  32'h1);
        check("sat_streak15", 32'(streak2), 32'hF);
      end
    end
    check("sat_cnt",    32'(fail_cnt2), 32'hF);
    check("sat_streak", 32'(streak2),   32'hF);
    check("sat_state",  32'(state2),    32'h2);
    check("sat_cnt_a",  32'(fail_cnt),  32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
